lcd_timing_driver: RTL

Raster timing generator and pixel output stage for the 24-bit LCD/VGA path. It runs horizontal and vertical counters, drives sync and data-enable to the panel, and publishes the coordinates of the next pixel one cycle early. It then takes the registered `lcd_data` returned by the pixel-source block and forwards it to the panel pins aligned with `lcd_de`. It sits between the character/graphics generators and the physical LCD connector.

---
 rtl/lcd_timing_driver.sv | 126 ++++++++++++
 1 files changed

// File: rtl/lcd_timing_driver.sv
// Raster timing generator and pixel output stage for a 24-bit LCD/VGA panel.
// Define LCD_TEST_PATTERN_EN to replace lcd_data with eight vertical colour bars.
module lcd_timing_driver #(
    parameter int unsigned H_SYNC  = 96,
    parameter int unsigned H_BACK  = 48,
    parameter int unsigned H_DISP  = 640,
    parameter int unsigned H_FRONT = 16,
    parameter int unsigned V_SYNC  = 2,
    parameter int unsigned V_BACK  = 33,
    parameter int unsigned V_DISP  = 480,
    parameter int unsigned V_FRONT = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [23:0] lcd_data,
    output logic        lcd_request,
    output logic [10:0] lcd_xpos,
    output logic [10:0] lcd_ypos,
    output logic        lcd_hs,
    output logic        lcd_vs,
    output logic        lcd_de,
    output logic [23:0] lcd_rgb,
    output logic        frame_start
);
    localparam int unsigned H_TOTAL = H_SYNC + H_BACK + H_DISP + H_FRONT;
    localparam int unsigned V_TOTAL = V_SYNC + V_BACK + V_DISP + V_FRONT;

    localparam logic [10:0] HLast     = 11'(H_TOTAL - 1);
    localparam logic [10:0] VLast     = 11'(V_TOTAL - 1);
    localparam logic [10:0] HSyncEnd  = 11'(H_SYNC);
    localparam logic [10:0] VSyncEnd  = 11'(V_SYNC);
    // Requests lead the horizontal active window by one clock.
    localparam logic [10:0] HReqStart = 11'(H_SYNC + H_BACK - 1);
    localparam logic [10:0] HReqEnd   = 11'(H_SYNC + H_BACK + H_DISP - 1);
    localparam logic [10:0] VActStart = 11'(V_SYNC + V_BACK);
    localparam logic [10:0] VActEnd   = 11'(V_SYNC + V_BACK + V_DISP);

    logic [10:0] hcnt_q, hcnt_d;
    logic [10:0] vcnt_q, vcnt_d;
    logic        hs_q, hs_d;
    logic        vs_q, vs_d;
    logic        de_q;
    logic        fs_q, fs_d;
    logic        h_req, v_act;
    logic [23:0] pixel;

    always_comb begin
        hcnt_d = hcnt_q + 11'd1;
        vcnt_d = vcnt_q;
        if (hcnt_q == HLast) begin
            hcnt_d = '0;
            vcnt_d = (vcnt_q == VLast) ? '0 : vcnt_q + 11'd1;
        end
    end

    always_comb begin
        h_req       = (hcnt_q >= HReqStart) && (hcnt_q < HReqEnd);
        v_act       = (vcnt_q >= VActStart) && (vcnt_q < VActEnd);
        lcd_request = h_req && v_act;
        lcd_xpos    = '0;
        lcd_ypos    = '0;
        if (lcd_request) begin
            lcd_xpos = hcnt_q - HReqStart;
            lcd_ypos = vcnt_q - VActStart;
        end
        hs_d = (hcnt_q >= HSyncEnd);
        vs_d = (vcnt_q >= VSyncEnd);
        fs_d = lcd_request && (lcd_xpos == '0) && (lcd_ypos == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hcnt_q <= '0;
            vcnt_q <= '0;
            hs_q   <= 1'b1;
            vs_q   <= 1'b1;
            de_q   <= 1'b0;
            fs_q   <= 1'b0;
        end else begin
            hcnt_q <= hcnt_d;
            vcnt_q <= vcnt_d;
            hs_q   <= hs_d;
            vs_q   <= vs_d;
            de_q   <= lcd_request;
            fs_q   <= fs_d;
        end
    end

`ifdef LCD_TEST_PATTERN_EN
    localparam logic [10:0] BarWidth = 11'(H_DISP / 8);

    logic [10:0] xpos_q;
    logic [10:0] bar;

    always_ff @(posedge clk) begin
        if (rst) begin
            xpos_q <= '0;
        end else begin
            xpos_q <= lcd_xpos;
        end
    end

    always_comb begin
        bar = xpos_q / BarWidth;
        case (bar)
            11'd0:   pixel = 24'hFFFFFF;
            11'd1:   pixel = 24'hFFFF00;
            11'd2:   pixel = 24'h00FFFF;
            11'd3:   pixel = 24'h00FF00;
            11'd4:   pixel = 24'hFF00FF;
            11'd5:   pixel = 24'hFF0000;
            11'd6:   pixel = 24'h0000FF;
            default: pixel = 24'h000000;
        endcase
    end
`else
    assign pixel = lcd_data;
`endif

    assign lcd_hs      = hs_q;
    assign lcd_vs      = vs_q;
    assign lcd_de      = de_q;
    assign frame_start = fs_q;
    assign lcd_rgb     = de_q ? pixel : 24'h0;

endmodule
